// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_BAUD_DIV = 434;
    localparam int MIN_BAUD_DIV     = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for PIN_RX with falling-edge detect; all flops preset high.
module uart_rx_sync (
    input  logic CLK,
    input  logic HRESET,
    input  logic PIN_RX,
    output logic rx_s,
    output logic fall
);

    localparam int STAGES = 2;

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK or negedge HRESET) begin
                    if (!HRESET) sync_reg[gi] <= 1'b1;
                    else         sync_reg[gi] <= PIN_RX;
                end
            end else begin : g_next
                always_ff @(posedge CLK or negedge HRESET) begin
                    if (!HRESET) sync_reg[gi] <= 1'b1;
                    else         sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Previous synchronized sample, preset high so reset release never looks like a start bit.
    always_ff @(posedge CLK or negedge HRESET) begin
        if (!HRESET) prev_reg <= 1'b1;
        else         prev_reg <= sync_reg[STAGES-1];
    end

    assign rx_s = sync_reg[STAGES-1];
    assign fall = prev_reg & ~sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-entry holding register, frame error and overrun flags.
module uart_rx #(
    parameter int DIV_WIDTH = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 HRESET,
    input  logic                 PIN_RX,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rx_enable,
    input  logic                 rx_read,
    output logic [7:0]           rx_data,
    output logic                 rx_full,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    import uart_pkg::*;

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .CLK    (CLK),
        .HRESET (HRESET),
        .PIN_RX (PIN_RX),
        .rx_s   (rx_s),
        .fall   (fall)
    );

    uart_state_t          state_reg, state_next;
    logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
    logic [DIV_WIDTH-1:0] div_reg, div_next;
    logic [2:0]           bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [7:0]           data_reg, data_next;
    logic                 full_reg, full_next;
    logic                 ferr_reg, ferr_next;
    logic                 ovr_reg, ovr_next;

    logic [DIV_WIDTH-1:0] div_clamped;

    assign div_clamped = (baud_div < DIV_WIDTH'(MIN_BAUD_DIV)) ? DIV_WIDTH'(MIN_BAUD_DIV) : baud_div;

    always_ff @(posedge CLK or negedge HRESET) begin
        if (!HRESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            full_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            full_reg  <= full_next;
            ferr_reg  <= ferr_next;
            ovr_reg   <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        full_next  = full_reg;
        ferr_next  = ferr_reg;
        ovr_next   = ovr_reg;

        // A read on its own empties the holding register; a commit below may refill it.
        if (rx_read && full_reg) begin
            full_next = 1'b0;
            ovr_next  = 1'b0;
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (rx_enable && fall) begin
                    div_next   = div_clamped;
                    cnt_next   = (div_clamped >> 1) - DIV_WIDTH'(1);
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (!rx_enable) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == '0) begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next   = div_reg - DIV_WIDTH'(1);
                        bit_next   = '0;
                        state_next = ST_DATA;
                    end
                end else begin
                    cnt_next = cnt_reg - DIV_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (!rx_enable) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == '0) begin
                    shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                    cnt_next   = div_reg - DIV_WIDTH'(1);
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'(DATA_BITS - 1)) state_next = ST_STOP;
                end else begin
                    cnt_next = cnt_reg - DIV_WIDTH'(1);
                end
            end
            ST_STOP: begin
                if (!rx_enable) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    if (!full_reg || rx_read) begin
                        data_next = shift_reg[7:0];
                        ferr_next = ~rx_s;
                        full_next = 1'b1;
                    end else begin
                        ovr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - DIV_WIDTH'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rx_data   = data_reg;
    assign rx_full   = full_reg;
    assign frame_err = ferr_reg;
    assign overrun   = ovr_reg;
    assign rx_busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed scoreboard bench for uart_rx driving 8N1 frames on PIN_RX.
module tb_uart_rx;

    logic        CLK;
    logic        HRESET;
    logic        PIN_RX;
    logic [15:0] baud_div;
    logic        rx_enable;
    logic        rx_read;
    logic [7:0]  rx_data;
    logic        rx_full;
    logic        frame_err;
    logic        overrun;
    logic        rx_busy;

    uart_rx #(.DIV_WIDTH(16), .DATA_BITS(8)) dut (
        .CLK       (CLK),
        .HRESET    (HRESET),
        .PIN_RX    (PIN_RX),
        .baud_div  (baud_div),
        .rx_enable (rx_enable),
        .rx_read   (rx_read),
        .rx_data   (rx_data),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: a byte with stop bit s is accepted as {data=b, frame_err=!s}.
    task automatic expect_byte(input logic [7:0] b, input logic stop);
        exp_t e;
        e.data = b;
        e.ferr = ~stop;
        exp_q.push_back(e);
    endtask

    // Drives one frame; called and returns one time unit after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            PIN_RX = f[i];
            repeat (div) @(posedge CLK);
            #1;
        end
        PIN_RX = 1'b1;
    endtask

    task automatic do_read();
        int n;
        n = 0;
        while (!rx_full && n < 20000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("read_wait_full", rx_full, 1'b1);
        rx_read = 1'b1;
        @(posedge CLK);
        #1;
        rx_read = 1'b0;
        check("read_clears_full", rx_full, 1'b0);
        check("read_clears_overrun", overrun, 1'b0);
    endtask

    // Monitor: a new byte is presented when rx_full rises, or stays high across a read.
    initial begin
        logic full_last, read_last;
        exp_t e;
        full_last = 1'b0;
        read_last = 1'b0;
        forever begin
            @(negedge CLK);
            if (HRESET && rx_full && (!full_last || read_last)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", rx_data, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", rx_data, e.data);
                    check("frame_err", frame_err, e.ferr);
                    $display("byte rx_data=%02h frame_err=%0d expected %02h/%0d",
                             rx_data, frame_err, e.data, e.ferr);
                end
            end
            full_last = rx_full;
            read_last = rx_read;
        end
    end

    initial begin
        int lat, busy_cnt;
        logic [7:0] b;
        logic       s;
        int         d;

        HRESET    = 1'b0;
        PIN_RX    = 1'b1;
        baud_div  = 16'd10;
        rx_enable = 1'b0;
        rx_read   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_full", rx_full, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        HRESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("post_rst_busy", rx_busy, 1'b0);
        rx_enable = 1'b1;

        // Basic byte and latency from start-bit fall to rx_full.
        expect_byte(8'hA5, 1'b1);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 10);
            begin
                while (!rx_full && lat < 300) begin
                    @(posedge CLK);
                    #1;
                    lat++;
                end
            end
        join
        check("latency_98", lat, 98);
        do_read();
        check("data_retained_after_read", rx_data, 8'hA5);
        rx_read = 1'b1;
        @(posedge CLK);
        #1;
        rx_read = 1'b0;
        check("read_empty_no_effect", rx_data, 8'hA5);

        // Short glitch must be rejected at the start-bit sample.
        PIN_RX = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        PIN_RX = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rx_busy) busy_cnt++;
            @(posedge CLK);
            #1;
        end
        check("glitch_busy_cycles", busy_cnt, 5);
        check("glitch_full", rx_full, 1'b0);
        check("glitch_data", rx_data, 8'hA5);
        $display("glitch busy_cycles=%0d", busy_cnt);

        // Framing error then a clean byte.
        expect_byte(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, 10);
        check("ferr_full", rx_full, 1'b1);
        check("ferr_flag", frame_err, 1'b1);
        do_read();
        expect_byte(8'h11, 1'b1);
        send_frame(8'h11, 1'b1, 10);
        check("ferr_cleared", frame_err, 1'b0);
        do_read();

        // Overrun: second byte discarded while the first is unread.
        expect_byte(8'h12, 1'b1);
        send_frame(8'h12, 1'b1, 10);
        send_frame(8'h34, 1'b1, 10);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_data_kept", rx_data, 8'h12);
        do_read();

        // Read coinciding with the stop-sample edge lets the new byte in.
        expect_byte(8'h12, 1'b1);
        send_frame(8'h12, 1'b1, 10);
        expect_byte(8'h34, 1'b1);
        fork
            send_frame(8'h34, 1'b1, 10);
            begin
                repeat (2 + 5 + 9 * 10) @(posedge CLK);
                #1;
                rx_read = 1'b1;
                @(posedge CLK);
                #1;
                rx_read = 1'b0;
            end
        join
        check("simul_read_full", rx_full, 1'b1);
        check("simul_read_overrun", overrun, 1'b0);
        check("simul_read_data", rx_data, 8'h34);
        do_read();

        // Back-to-back frames at the default divider.
        baud_div = 16'd434;
        expect_byte(8'h00, 1'b1);
        expect_byte(8'hFF, 1'b1);
        expect_byte(8'h55, 1'b1);
        fork
            begin
                send_frame(8'h00, 1'b1, 434);
                send_frame(8'hFF, 1'b1, 434);
                send_frame(8'h55, 1'b1, 434);
            end
            begin
                repeat (3) do_read();
            end
        join

        // Divider change mid-frame is ignored for the current byte.
        baud_div = 16'd10;
        expect_byte(8'hC3, 1'b1);
        fork
            send_frame(8'hC3, 1'b1, 10);
            begin
                repeat (30) @(posedge CLK);
                #1;
                baud_div = 16'd3;
            end
        join
        baud_div = 16'd10;
        do_read();

        // Disable mid-frame: abort without commit, next frame still good.
        fork
            send_frame(8'hE7, 1'b1, 10);
            begin
                repeat (40) @(posedge CLK);
                #1;
                check("dis_busy_before", rx_busy, 1'b1);
                rx_enable = 1'b0;
                @(posedge CLK);
                #1;
                check("dis_busy_after", rx_busy, 1'b0);
            end
        join
        repeat (5) @(posedge CLK);
        #1;
        check("dis_no_commit", rx_full, 1'b0);
        rx_enable = 1'b1;
        expect_byte(8'h96, 1'b1);
        send_frame(8'h96, 1'b1, 10);
        do_read();

        // Reset mid-frame with an unread byte held.
        expect_byte(8'h77, 1'b1);
        send_frame(8'h77, 1'b1, 10);
        fork
            send_frame(8'h5A, 1'b1, 10);
            begin
                repeat (40) @(posedge CLK);
                #1;
                check("rst_mid_busy_before", rx_busy, 1'b1);
                HRESET = 1'b0;
                #1;
                check("rst_mid_full", rx_full, 1'b0);
                check("rst_mid_data", rx_data, 8'h00);
                check("rst_mid_busy", rx_busy, 1'b0);
            end
        join
        repeat (3) @(posedge CLK);
        #1;
        HRESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        expect_byte(8'h0F, 1'b1);
        send_frame(8'h0F, 1'b1, 10);
        do_read();

        // Divider values below the minimum behave as 2.
        baud_div = 16'd0;
        expect_byte(8'h6E, 1'b1);
        send_frame(8'h6E, 1'b1, 2);
        do_read();
        baud_div = 16'd1;
        expect_byte(8'hB1, 1'b0);
        send_frame(8'hB1, 1'b0, 2);
        do_read();

        // Randomized frames, dividers and stop bits.
        for (int i = 0; i < 12; i++) begin
            d = $urandom_range(2, 16);
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            baud_div = 16'(d);
            expect_byte(b, s);
            send_frame(b, s, d);
            do_read();
            repeat ($urandom_range(0, 4)) @(posedge CLK);
            #1;
        end

        repeat (20) @(posedge CLK);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive half of the UART peripheral, complementing the existing transmit path.
- Samples the asynchronous PIN_RX line at mid-bit using a programmable per-bit cycle count, shifts in LSB-first data and holds the byte in a one-entry holding register.
- Reports frame error and overrun flags.
- Sits beside the transmitter inside the UART top; the bus-register decode in the top drives baud_div, rx_enable and rx_read.

Parameters:
- DIV_WIDTH, 16: width of baud_div and the internal bit counter.
- DATA_BITS, 8: data bits per frame. Fixed at 8; other values are not supported.

Ports:
- CLK  input  1  system clock; all state is on the rising edge.
- HRESET  input  1  reset, asynchronous, active-low.
- PIN_RX  input  1  asynchronous serial line; idles high.
- baud_div  input  DIV_WIDTH  CLK cycles per bit; 434 gives 115200 baud at 50 MHz.
- rx_enable  input  1  receiver enable.
- rx_read  input  1  one-cycle pulse: consumer takes rx_data and clears rx_full and overrun.
- rx_data  output  8  holding-register byte.
- rx_full  output  1  holding register contains an unread byte.
- frame_err  output  1  stop bit of the byte in rx_data sampled 0.
- overrun  output  1  sticky; a completed byte was discarded because the holding register was full.
- rx_busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async on HRESET low):
  - rx_data=0, rx_full=0, frame_err=0, overrun=0, rx_busy=0.
  - FSM in IDLE, shift register 0.
  - Synchronizer flops preset to 1 so reset release never produces a false start.
- Input sync: PIN_RX passes through 2 flops (rx_s). A falling edge is rx_s=0 with the previous rx_s=1.
- Divider: on the edge that leaves IDLE, latch div_l = max(baud_div, 2). Changes to baud_div mid-frame are ignored. half = div_l>>1.
- FSM states:
  - IDLE: if rx_enable and a falling edge is seen, load cnt=half-1 and go to START.
  - START: cnt counts down to 0, then sample rx_s. If it is 1 (glitch), return to IDLE with no flags changed. If it is 0, load cnt=div_l-1, bit index=0, go to DATA.
  - DATA: at cnt==0, shift rx_s into the MSB of the shift register (LSB-first line order) and reload cnt=div_l-1. After the 8th sample, go to STOP.
  - STOP: at cnt==0, sample the stop bit, commit (below) and go to IDLE on the same edge, so back-to-back frames are accepted.
- Commit (at the stop-sample edge, visible the next cycle):
  - If rx_full=0, or rx_read is asserted in the same cycle: rx_data=shift, frame_err=~rx_s, rx_full=1.
  - Otherwise: byte discarded, overrun=1, rx_data and frame_err unchanged.
- rx_read without a commit in the same cycle: rx_full=0, overrun=0. rx_data and frame_err are retained.
- rx_read while rx_full=0: no effect.
- rx_enable deasserted in any non-IDLE state: return to IDLE next cycle, no commit, flags untouched.
- Timing: each sample lands at half + k·div_l cycles after the synchronized falling edge. rx_full asserts 1 cycle after the stop sample, 2+half+9·div_l+1 cycles after the PIN_RX fall.
- rx_busy = (state != IDLE), registered from the state.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE, START, DATA, STOP), DATA_BITS=8, DEFAULT_BAUD_DIV=434, MIN_BAUD_DIV=2. The transmitter shares this package.
- Sub-module uart_rx_sync: 2-flop synchronizer preset to 1 plus falling-edge detect; outputs rx_s and fall.
- Everything else stays in uart_rx.

Test Plan:
- Byte reception: baud_div=10, rx_enable=1, send 0xA5 (8N1) on PIN_RX -> rx_full rises exactly 98 cycles after the start-bit fall; rx_data=0xA5, frame_err=0. A rx_read pulse then clears rx_full.
- Glitch rejection: a 3-cycle low pulse on an idle line -> rx_busy high for about 5 cycles then 0; rx_full, rx_data and flags unchanged.
- Framing error: send 0x3C with stop bit driven 0 -> rx_data=0x3C, frame_err=1, rx_full=1. Then send 0x11 correctly and read -> frame_err=0.
- Overrun and simultaneous read: send 0x12 then 0x34 without reading -> rx_data=0x12, overrun=1. After rx_read, overrun=0. Repeat with rx_read asserted exactly at the 0x34 stop-sample cycle -> rx_data=0x34, rx_full=1, overrun=0.
- Back-to-back and baud change: send 0x00, 0xFF, 0x55 with no idle gap at baud_div=434 -> all three received in order with reads between frames. Changing baud_div mid-frame does not corrupt the current byte.
- Reset/disable mid-frame: assert HRESET low during the DATA state -> all outputs return to reset values immediately. Deassert rx_enable mid-frame -> return to IDLE, no commit, and the next full frame is received correctly.
